pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage pipeline: fetch, decode, execute, memory, writeback.
- Decides each cycle which stage instruction registers hold (stall) and which load the NOP bubble.
- Drives operand forwarding selects and the branch PC select, using the destination registers reported by the execute, memory and writeback stage units.
- Holds an FSM for branch-flush and memory-wait sequencing, plus a saturating stall-cycle counter.

Parameters:
- FLUSH_EXTRA, 1: extra cycles decode is flushed after a taken branch, covering the instruction-memory read latency (0..3).
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, active-low
- dec_rn, dec_rm, dec_rs  in  4 each  decode-stage source registers
- dec_use_rn, dec_use_rm, dec_use_rs  in  1 each  source actually read
- ex_rt  in  4  execute-stage destination
- ex_wr  in  1  execute instruction writes ex_rt
- ex_is_load  in  1  execute instruction is a load (LDR)
- mem_rt  in  4  memory-stage destination
- mem_wr  in  1  memory instruction writes mem_rt
- wb_rt  in  4  writeback-stage destination
- wb_wr  in  1  writeback instruction writes wb_rt
- branch_taken  in  1  execute resolved a taken branch this cycle
- mem_wait  in  1  data memory not ready
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold that stage register
- flush_id  out  1  load NOP into decode instr reg
- bubble_ex  out  1  load NOP into execute instr reg
- bubble_wb  out  1  load NOP into writeback instr reg
- pc_sel  out  1  1 = PC loads branch target
- fwd_rn, fwd_rm, fwd_rs  out  2 each  00 regfile, 01 ex, 10 mem, 11 wb
- state  out  2  00 RUN, 01 FLUSH, 10 MEMWAIT
- stall_cycles  out  CNT_W  saturating penalty counter

Behaviour:
- Reset: rst_n is asynchronous and active-low.
  - state=RUN, flush counter=0, stall_cycles=0.
  - While rst_n=0, outputs are forced to: flush_id=1, bubble_ex=1, bubble_wb=1; all stalls=0; pc_sel=0; fwd_*=00.
  - Reset mid-FLUSH or mid-MEMWAIT returns to RUN immediately.
- Control outputs are combinational from the registered state and the current inputs. state and stall_cycles update on posedge clk.
- Priority each cycle: mem_wait > branch_taken > load-use > normal.
- MEMWAIT:
  - Entered from any state when mem_wait=1, and held while mem_wait=1.
  - Drives stall_if=stall_id=stall_ex=stall_mem=1 and bubble_wb=1. pc_sel=0, flush_id=0, bubble_ex=0.
  - The flush counter is frozen. On mem_wait=0, return to the saved prior state (RUN or FLUSH with its remaining count).
  - A branch_taken that arrives during MEMWAIT is held in execute and is acted on in the first cycle after mem_wait falls.
- Branch (RUN, branch_taken=1, mem_wait=0):
  - Drives pc_sel=1, flush_id=1, bubble_ex=1.
  - Next state is FLUSH with count=FLUSH_EXTRA; if FLUSH_EXTRA=0, stay in RUN.
- FLUSH:
  - Drives flush_id=1 and decrements the count each cycle; on reaching 0, go to RUN.
  - branch_taken and load-use are ignored (wrong-path instructions).
- Load-use hazard (RUN, no branch): any used source s with s==ex_rt, ex_wr=1, ex_is_load=1 and s!=15.
  - Drives stall_if=stall_id=1 and bubble_ex=1 for exactly one cycle.
  - The next cycle the load is in memory and is forwarded with code 10.
- Forwarding, per source, independent of state:
  - If the source is not used or equals 15, select 00.
  - Else the youngest match wins: ex (ex_wr=1 and ex_is_load=0) → 01; else mem (mem_wr=1) → 10; else wb (wb_wr=1) → 11; else 00.
  - An ex match with ex_is_load=1 never gives 01; the check falls through to mem/wb.
- stall_cycles increments by 1 on every clock edge where stall_if=1 or flush_id=1. It saturates at all-ones and never wraps.

Test Plan:
- Reset release with all inputs 0 → state=00, stall_cycles=0; the next cycle all stalls/flush/bubble=0, fwd_*=00.
- Back-to-back ALU dependency: dec_rn=3 used; ex_rt=3, ex_wr=1; mem_rt=3, mem_wr=1 → fwd_rn=01. With ex_wr=0 → fwd_rn=10. With dec_rn=15 → 00.
- Load-use: ex_rt=5, ex_is_load=1, ex_wr=1, dec_rm=5 used → stall_if=stall_id=bubble_ex=1 for 1 cycle only; stall_cycles +1.
- Taken branch, FLUSH_EXTRA=1:
  - Branch cycle → pc_sel=1, flush_id=1, bubble_ex=1.
  - Next cycle → state=01, flush_id=1, pc_sel=0.
  - Then state=00; stall_cycles +2.
- mem_wait for 3 cycles arriving during FLUSH → state=10 with all stalls + bubble_wb=1 for 3 cycles; then FLUSH resumes for its remaining cycle.
- branch_taken and mem_wait together, then mem_wait drops → no pc_sel while waiting; pc_sel=1 in the first cycle after. Separately, assert rst_n=0 mid-MEMWAIT → state=00 immediately.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/bubble sequencing, operand forwarding and branch PC select
// for the 5-stage pipeline, with a saturating stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int FLUSH_EXTRA = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       dec_rn,
  input  logic [3:0]       dec_rm,
  input  logic [3:0]       dec_rs,
  input  logic             dec_use_rn,
  input  logic             dec_use_rm,
  input  logic             dec_use_rs,
  input  logic [3:0]       ex_rt,
  input  logic             ex_wr,
  input  logic             ex_is_load,
  input  logic [3:0]       mem_rt,
  input  logic             mem_wr,
  input  logic [3:0]       wb_rt,
  input  logic             wb_wr,
  input  logic             branch_taken,
  input  logic             mem_wait,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             bubble_wb,
  output logic             pc_sel,
  output logic [1:0]       fwd_rn,
  output logic [1:0]       fwd_rm,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {RUN = 2'b00, FLUSH = 2'b01, MEMWAIT = 2'b10} state_t;
  state_t cur, nxt, saved, saved_nxt, eff;
  logic [1:0] cnt, cnt_nxt;
  logic [11:0] srcs;
  logic [2:0] uses, lu;
  logic [5:0] fwds;
  logic s_if, s_id, s_ex, s_mem, fid, bex, bwb, pcs;
  assign srcs = {dec_rs, dec_rm, dec_rn};
  assign uses = {dec_use_rs, dec_use_rm, dec_use_rn};
  for (genvar i = 0; i < 3; i++) begin : g_src
    logic [3:0] s;
    assign s = srcs[4*i +: 4];
    assign lu[i] = uses[i] && s != 4'd15 && ex_wr && ex_is_load && s == ex_rt;
    assign fwds[2*i +: 2] = (!rst_n || !uses[i] || s == 4'd15) ? 2'b00 :
                            (ex_wr && !ex_is_load && s == ex_rt) ? 2'b01 :
                            (mem_wr && s == mem_rt) ? 2'b10 :
                            (wb_wr && s == wb_rt) ? 2'b11 : 2'b00;
  end
  assign {fwd_rs, fwd_rm, fwd_rn} = fwds;
  // Once mem_wait drops, MEMWAIT behaves as the saved state that same cycle, so a held branch acts at once.
  always_comb begin
    eff = (cur == MEMWAIT) ? saved : cur;
    nxt = eff;
    saved_nxt = saved;
    cnt_nxt = cnt;
    {s_if, s_id, s_ex, s_mem, fid, bex, bwb, pcs} = '0;
    if (mem_wait) begin
      {s_if, s_id, s_ex, s_mem, bwb} = '1;
      nxt = MEMWAIT;
      saved_nxt = eff;
    end else if (eff == FLUSH) begin
      fid = 1'b1;
      cnt_nxt = cnt - 2'd1;
      nxt = (cnt <= 2'd1) ? RUN : FLUSH;
    end else if (branch_taken) begin
      {pcs, fid, bex} = '1;
      nxt = (FLUSH_EXTRA == 0) ? RUN : FLUSH;
      cnt_nxt = 2'(FLUSH_EXTRA);
    end else if (|lu) begin
      {s_if, s_id, bex} = '1;
    end
  end
  assign stall_if  = rst_n && s_if;
  assign stall_id  = rst_n && s_id;
  assign stall_ex  = rst_n && s_ex;
  assign stall_mem = rst_n && s_mem;
  assign pc_sel    = rst_n && pcs;
  assign flush_id  = !rst_n || fid;
  assign bubble_ex = !rst_n || bex;
  assign bubble_wb = !rst_n || bwb;
  assign state     = cur;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= RUN;
      saved <= RUN;
      cnt <= '0;
      stall_cycles <= '0;
    end else begin
      cur <= nxt;
      saved <= saved_nxt;
      cnt <= cnt_nxt;
      if ((s_if || fid) && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule
